// File: rtl/sid_pwm_dac.sv
// Audio PWM stage: 12-bit signed mixer sample -> 256-clock carrier with 4-bit error-feedback dither and power-up soft-start ramp.
// Duty applies from the period after the boundary that computed it; no back-pressure, samples are captured whenever strobed.
module sid_pwm_dac #(
  parameter int SAMPLE_W = 12,
  parameter int PWM_BITS = 8,
  parameter int MID_DUTY = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic                mute,
  output logic                pwm_out,
  output logic                period_start,
  output logic                ramp_done
);

  localparam int ERR_W = SAMPLE_W - PWM_BITS;

  typedef enum logic {S_RAMP, S_RUN} state_t;

  state_t              r_state;
  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] r_ramp_val;
  logic [ERR_W-1:0]    r_err;
  logic [SAMPLE_W-1:0] r_sample_hold;

  logic                w_boundary;
  logic [SAMPLE_W-1:0] w_u;
  logic [SAMPLE_W:0]   w_acc;

  assign w_boundary = (r_cnt == {PWM_BITS{1'b1}});
  // Offset binary keeps the carry-out of the dither add as the saturation flag.
  assign w_u   = {~r_sample_hold[SAMPLE_W-1], r_sample_hold[SAMPLE_W-2:0]};
  assign w_acc = {1'b0, w_u} + {{(SAMPLE_W+1-ERR_W){1'b0}}, r_err};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_RAMP;
      r_cnt         <= '0;
      r_duty        <= '0;
      r_ramp_val    <= '0;
      r_err         <= '0;
      r_sample_hold <= '0;
      pwm_out       <= 1'b0;
      period_start  <= 1'b0;
      ramp_done     <= 1'b0;
    end else begin
      r_cnt        <= r_cnt + 1'b1;
      period_start <= w_boundary;
      pwm_out      <= (r_cnt < r_duty);
      if (sample_valid) begin
        r_sample_hold <= sample_in;
      end
      if (w_boundary) begin
        case (r_state)
          S_RAMP: begin
            r_duty <= r_ramp_val;
            r_err  <= '0;
            if (r_ramp_val == PWM_BITS'(MID_DUTY)) begin
              r_state   <= S_RUN;
              ramp_done <= 1'b1;
            end else begin
              r_ramp_val <= r_ramp_val + 1'b1;
            end
          end
          S_RUN: begin
            if (mute) begin
              r_duty <= PWM_BITS'(MID_DUTY);
              r_err  <= '0;
            end else if (w_acc[SAMPLE_W]) begin
              r_duty <= '1;
              r_err  <= '1;
            end else begin
              r_duty <= w_acc[SAMPLE_W-1:ERR_W];
              r_err  <= w_acc[ERR_W-1:0];
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sid_pwm_dac.sv
// Randomized bench for sid_pwm_dac: per-cycle check against an edge-count reference model plus literal period high-count checks.
module tb_sid_pwm_dac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        mute = 1'b0;
  logic        pwm_out, period_start, ramp_done;

  int n_cmp = 0;
  int n_err = 0;

  sid_pwm_dac dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .mute(mute), .pwm_out(pwm_out), .period_start(period_start), .ramp_done(ramp_done)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: everything derives from the number of clock edges since reset release.
  int edges = 0;
  int m_duty = 0;
  int m_err = 0;
  int m_hold = 0;
  bit exp_pwm = 0, exp_ps = 0, exp_rd = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edges = 0; m_duty = 0; m_err = 0; m_hold = 0;
      exp_pwm = 0; exp_ps = 0; exp_rd = 0;
    end else begin
      int k, t;
      edges++;
      exp_pwm = ((edges - 1) % 256) < m_duty;
      exp_ps  = (edges % 256) == 0;
      if (edges % 256 == 0) begin
        k = edges / 256;
        if (k <= 129) begin
          m_duty = k - 1;
        end else if (mute) begin
          m_duty = 128; m_err = 0;
        end else begin
          t = m_hold + 2048 + m_err;
          if (t > 4095) begin
            m_duty = 255; m_err = 15;
          end else begin
            m_duty = t / 16; m_err = t % 16;
          end
        end
      end
      exp_rd = edges >= 33024;
      if (sample_valid) m_hold = $signed(sample_in);
    end
  end

  always @(negedge clk) begin
    check("pwm_out", int'(pwm_out), int'(exp_pwm));
    check("period_start", int'(period_start), int'(exp_ps));
    check("ramp_done", int'(ramp_done), int'(exp_rd));
  end

  task automatic wait_ps(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!period_start && n < 600) begin
      @(negedge clk);
      n++;
    end
    ok = period_start;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL wait_period_start: timeout got 0 expected 1");
    end
  endtask

  task automatic measure(string name, int exp);
    bit ok;
    int hi = 0;
    wait_ps(ok);
    if (ok) begin
      for (int i = 0; i < 256; i++) begin
        if (i > 0) @(negedge clk);
        hi += int'(pwm_out);
      end
      check(name, hi, exp);
    end
  endtask

  task automatic apply(logic [11:0] s, logic m);
    bit ok;
    wait_ps(ok);
    sample_in = s; sample_valid = 1'b1; mute = m;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  initial begin
    bit ok;
    int n;
    repeat (4) @(negedge clk);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_ramp_done", int'(ramp_done), 0);
    rst_n = 1'b1;

    n = 0;
    while (n < 34000) begin
      @(negedge clk);
      n++;
      if (ramp_done) break;
    end
    check("ramp_done_edge", n, 33024);

    apply(12'h000, 1'b0);
    measure("zero_p0", 128);
    measure("zero_p1", 128);

    apply(12'h7FF, 1'b0);
    measure("max_p0", 255);
    measure("max_p1", 255);

    apply(12'h800, 1'b0);
    measure("min_p0", 0);
    measure("min_p1", 0);

    apply(12'h400, 1'b1);
    measure("mute_p0", 128);
    mute = 1'b0;
    measure("unmute_p0", 192);

    apply(12'h008, 1'b0);
    measure("dither_p0", 128);
    measure("dither_p1", 129);
    measure("dither_p2", 128);
    measure("dither_p3", 129);

    apply(12'h000, 1'b0);
    wait_ps(ok);
    repeat (255) @(negedge clk);
    sample_in = 12'h400; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    measure("race_old", 128);
    measure("race_new", 192);

    for (int i = 0; i < 20 * 256; i++) begin
      @(negedge clk);
      sample_valid = ($urandom_range(0, 39) == 0);
      sample_in = 12'($urandom);
      if ($urandom_range(0, 999) == 0) mute = ~mute;
    end
    sample_valid = 1'b0;
    mute = 1'b0;

    apply(12'h400, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pwm_out && n < 600);
    check("pwm_high_before_reset", int'(pwm_out), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_pwm", int'(pwm_out), 0);
    check("async_ramp_done", int'(ramp_done), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    measure("rst_ramp0", 0);
    measure("rst_ramp1", 1);
    measure("rst_ramp2", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sid_pwm_dac.md
Name: sid_pwm_dac

Overview:
- Audio output stage of tt_um_sid. Sits directly downstream of the filter/volume mixer and drives uo_out[0].
- Converts the 12-bit signed mixer sample into a fixed-carrier PWM stream: 256-clock period, 93.75 kHz at 24 MHz.
- Uses 4-bit error-feedback dither to keep the sub-LSB resolution lost by the 8-bit duty.
- Performs a power-up soft-start ramp to mid-scale, so the external RC filter does not pop.

Parameters:
SAMPLE_W, 12, mixer sample width (signed two's complement)
PWM_BITS, 8, duty/counter width; carrier period = 2^PWM_BITS clocks
MID_DUTY, 128, idle/mute duty (2^(PWM_BITS-1))

Ports:
clk  input  1  system clock (24 MHz)
rst_n  input  1  reset, active-low
sample_in  input  12  signed mixer output
sample_valid  input  1  one-cycle strobe; sample_in is valid this cycle
mute  input  1  level; forces mid-scale output while high (RUN state only)
pwm_out  output  1  registered PWM bit, to uo_out[0]
period_start  output  1  registered one-cycle pulse while cnt==0, marking each carrier period
ramp_done  output  1  high once soft-start is complete; sticky until reset

Behaviour:
- Reset is asynchronous, active-low, single clock domain. On assertion all state clears immediately:
  - cnt=0, duty_reg=0, err=0, sample_hold=0, ramp_val=0, state=RAMP
  - pwm_out=0, period_start=0, ramp_done=0
- Reset mid-period: pwm_out drops low asynchronously and the ramp restarts from 0.
- Counter: cnt is 8 bits, increments every clock and wraps 255->0.
- Boundary: the clock edge where cnt==255. All duty_reg and err updates occur only at a boundary.
- period_start <= (cnt==255), so it is high exactly while cnt==0. It is not high in the first cycle after reset.
- pwm_out <= (cnt < duty_reg), a one-cycle lag behind cnt.
  - High count per period = duty_reg, range 0..255.
  - duty 0 gives constant low; 255 gives low for 1 clock in 256.
- Sample capture: on sample_valid, sample_hold <= sample_in.
  - If sample_valid coincides with a boundary, the boundary computation uses the old sample_hold. The new sample applies from the following boundary.
  - Several sample_valid pulses within one period: the last one wins.
- Conversion at a RUN boundary with mute=0:
  - u = sample_hold with MSB inverted (offset binary, 0..4095)
  - acc = {1'b0,u} + err, 13 bits
  - If acc[12]=1: saturate, duty_reg=255, err=15
  - Otherwise: duty_reg=acc[11:4], err=acc[3:0]
- State machine:
  - RAMP: at each boundary duty_reg <= ramp_val. If ramp_val==MID_DUTY go to RUN and set ramp_done=1; else ramp_val <= ramp_val+1.
  - RAMP: err is held at 0. Samples are captured but not used. mute is ignored.
  - RUN: conversion as above.
  - RUN with mute=1 at a boundary: duty_reg=MID_DUTY, err=0. When mute is released, normal conversion resumes at the next boundary.
  - RUN is terminal until reset.
- Ramp timing, counting edges after rst_n release:
  - Boundary k occurs at edge 256k and loads duty k-1.
  - Boundary 129 (edge 33024) loads 128 and asserts ramp_done.
  - The first sample-derived duty loads at boundary 130 (edge 33280).
- The mixer sample rate is asynchronous to the carrier. No handshake back-pressure; samples are never stalled.

Test Plan:
- Reset release, idle inputs -> high counts per successive period 0,1,2,...,128. ramp_done rises at edge 33024. pwm_out=0 throughout reset.
- After ramp, sample_in=0x000 -> every period has 128 high clocks; err stays 0.
- Full scale:
  - sample_in=0x7FF -> 255 high clocks every period (saturation path, err=15).
  - sample_in=0x800 -> pwm_out constantly 0.
- Dither, sample_in=0x008 (u=2056) -> duties alternate 128,129,128,129..., averaging 128.5.
- Mute and boundary races:
  - mute=1 in RUN with sample 0x400 -> the next period shows 128 high clocks; after mute drops, duty returns to 192.
  - sample_valid coincident with a boundary -> the new value appears one period later.
- Reset mid-period: assert rst_n=0 while pwm_out=1 -> pwm_out=0 asynchronously, ramp_done=0, the ramp sequence restarts from duty 0.
